// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver: 2-flop synchronizer, 3-sample majority vote at mid-bit,
// false-start filtering and framing-error discard. Strobes are single-cycle.
module uart_byte_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rxd,
  output logic [7:0] o_rx_data,
  output logic       o_data_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_sync1, r_sync2;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bidx;
  logic [7:0]      r_shift;
  logic            r_s0, r_s1;
  logic [7:0]      r_rx_data;
  logic            r_dv, r_fe;

  logic w_rxd_s, w_vote, w_mid, w_bit_end;
  logic w_cnt_clr, w_shift_en, w_good, w_bad, w_bidx_inc, w_bidx_clr;

  assign w_rxd_s   = r_sync2;
  assign w_mid     = (r_cnt == CW'(H + 1));
  assign w_bit_end = (r_cnt == CW'(CLKS_PER_BIT - 1));
  // Third sample is taken live at cnt = H+1, so the vote is usable that cycle.
  assign w_vote    = (r_s0 & r_s1) | (r_s0 & w_rxd_s) | (r_s1 & w_rxd_s);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rxd;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_shift_en  = 1'b0;
    w_good      = 1'b0;
    w_bad       = 1'b0;
    w_bidx_inc  = 1'b0;
    w_bidx_clr  = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_clr = 1'b1;
        if (!w_rxd_s) w_state_nxt = START;
      end
      START: begin
        if (w_mid && w_vote) begin
          w_state_nxt = IDLE;
          w_cnt_clr   = 1'b1;
        end else if (w_bit_end) begin
          w_state_nxt = DATA;
          w_cnt_clr   = 1'b1;
          w_bidx_clr  = 1'b1;
        end
      end
      DATA: begin
        if (w_mid) w_shift_en = 1'b1;
        if (w_bit_end) begin
          w_cnt_clr  = 1'b1;
          w_bidx_inc = 1'b1;
          if (r_bidx == 3'd7) w_state_nxt = STOP;
        end
      end
      STOP: begin
        // Decide at mid-bit so a back-to-back start edge is seen without skew.
        if (w_mid) begin
          w_cnt_clr = 1'b1;
          if (w_vote) begin
            w_good      = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_bad       = 1'b1;
            w_state_nxt = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        w_cnt_clr = 1'b1;
        if (w_rxd_s) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_clr   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bidx    <= '0;
      r_shift   <= '0;
      r_s0      <= 1'b1;
      r_s1      <= 1'b1;
      r_rx_data <= '0;
      r_dv      <= 1'b0;
      r_fe      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_clr ? '0 : r_cnt + CW'(1);
      if (w_bidx_clr)      r_bidx <= '0;
      else if (w_bidx_inc) r_bidx <= r_bidx + 3'd1;
      if (r_cnt == CW'(H - 1)) r_s0 <= w_rxd_s;
      if (r_cnt == CW'(H))     r_s1 <= w_rxd_s;
      if (w_shift_en) r_shift <= {w_vote, r_shift[7:1]};
      if (w_good)     r_rx_data <= r_shift;
      r_dv <= w_good;
      r_fe <= w_bad;
    end
  end

  assign o_rx_data    = r_rx_data;
  assign o_data_valid = r_dv;
  assign o_frame_err  = r_fe;
  assign o_busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// Randomized self-checking bench for uart_byte_rx at 16 clk/bit; the reference
// model is the sequence of bytes/frame outcomes the bench itself chose to send.
module tb_uart_byte_rx;
  localparam int CPB = 16;
  localparam int H   = CPB / 2;
  // Start bit is driven half a cycle before the edge that first captures it.
  localparam int LAT = 2 + 9 * CPB + H + 2 + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] rx_data;
  logic       data_valid, frame_err, busy;

  uart_byte_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .i_rxd(rxd),
    .o_rx_data(rx_data), .o_data_valid(data_valid),
    .o_frame_err(frame_err), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] dv_q[$];
  int         dv_t[$];
  int         fe_cnt = 0, both_cnt = 0, multi_cnt = 0, busy_cyc = 0;
  logic       prev_dv = 1'b0, prev_fe = 1'b0;

  always @(negedge clk) begin
    if (data_valid) begin
      dv_q.push_back(rx_data);
      dv_t.push_back(cyc);
    end
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (data_valid && frame_err) both_cnt <= both_cnt + 1;
    if ((data_valid && prev_dv) || (frame_err && prev_fe)) multi_cnt <= multi_cnt + 1;
    if (busy) busy_cyc <= busy_cyc + 1;
    prev_dv <= data_valid;
    prev_fe <= frame_err;
  end

  int         nchk = 0, npass = 0;
  int         last_start = 0;
  logic [7:0] exp_rx = 8'h00;

  // Sends one 8N1 frame with bit period per100/100 clk. Optional one-clk
  // inversion at (spike_bit, spike_off); stops early after max_cyc clk.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int per100,
                            input int spike_bit, input int spike_off, input int max_cyc);
    int   tot, b;
    logic v;
    tot = (10 * per100) / 100;
    for (int i = 0; i < tot && i < max_cyc; i++) begin
      b = 0;
      while (b < 9 && i >= ((b + 1) * per100) / 100) b++;
      if (b == 0)      v = 1'b0;
      else if (b == 9) v = stop;
      else             v = d[b-1];
      if (b == spike_bit && (i - (b * per100) / 100) == spike_off) v = ~v;
      @(negedge clk);
      rxd = v;
      if (i == 0) last_start = cyc;
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    nchk++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h want 00", rx_data); else npass++;
    nchk++; if (data_valid !== 1'b0) $display("FAIL reset_dv: got %b want 0", data_valid); else npass++;
    nchk++; if (frame_err !== 1'b0) $display("FAIL reset_fe: got %b want 0", frame_err); else npass++;
    nchk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else npass++;
    rst_n = 1'b1;
    idle(5);
  endtask

  task automatic test_single();
    int b0, f0;
    b0 = dv_q.size(); f0 = fe_cnt;
    send_frame(8'h46, 1'b1, 1600, -1, 0, 1000);
    idle(30);
    exp_rx = 8'h46;
    nchk++; if (dv_q.size() - b0 !== 1) $display("FAIL single_count: got %0d want 1", dv_q.size() - b0); else npass++;
    if (dv_q.size() > b0) begin
      nchk++; if (dv_q[b0] !== 8'h46) $display("FAIL single_data: got %h want 46", dv_q[b0]); else npass++;
      nchk++; if (dv_t[b0] - last_start !== LAT) $display("FAIL single_latency: got %0d want %0d", dv_t[b0] - last_start, LAT); else npass++;
    end
    nchk++; if (fe_cnt !== f0) $display("FAIL single_fe: got %0d want %0d", fe_cnt, f0); else npass++;
    nchk++; if (busy !== 1'b0) $display("FAIL single_busy: got %b want 0", busy); else npass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes[5];
    int b0;
    bytes = '{8'h4D, 8'h03, 8'h12, 8'h34, 8'h56};
    b0 = dv_q.size();
    for (int k = 0; k < 5; k++) send_frame(bytes[k], 1'b1, 1600, -1, 0, 1000);
    idle(30);
    exp_rx = 8'h56;
    nchk++; if (dv_q.size() - b0 !== 5) $display("FAIL b2b_count: got %0d want 5", dv_q.size() - b0); else npass++;
    for (int k = 0; k < 5 && b0 + k < dv_q.size(); k++) begin
      nchk++; if (dv_q[b0+k] !== bytes[k]) $display("FAIL b2b_data%0d: got %h want %h", k, dv_q[b0+k], bytes[k]); else npass++;
      if (k > 0) begin
        nchk++; if (dv_t[b0+k] - dv_t[b0+k-1] !== 10 * CPB)
          $display("FAIL b2b_spacing%0d: got %0d want %0d", k, dv_t[b0+k] - dv_t[b0+k-1], 10 * CPB); else npass++;
      end
    end
  endtask

  task automatic test_false_start();
    int b0, f0, bc0;
    b0 = dv_q.size(); f0 = fe_cnt; bc0 = busy_cyc;
    @(negedge clk); rxd = 1'b0;
    repeat (3) @(negedge clk);
    idle(40);
    nchk++; if (busy_cyc == bc0) $display("FAIL false_busy_pulse: got 0 busy cycles want >0"); else npass++;
    nchk++; if (dv_q.size() !== b0) $display("FAIL false_dv: got %0d want %0d", dv_q.size(), b0); else npass++;
    nchk++; if (fe_cnt !== f0) $display("FAIL false_fe: got %0d want %0d", fe_cnt, f0); else npass++;
    nchk++; if (busy !== 1'b0) $display("FAIL false_busy_end: got %b want 0", busy); else npass++;
    nchk++; if (rx_data !== exp_rx) $display("FAIL false_rx_data: got %h want %h", rx_data, exp_rx); else npass++;
  endtask

  task automatic test_frame_err();
    int b0, f0;
    b0 = dv_q.size(); f0 = fe_cnt;
    send_frame(8'hA5, 1'b0, 1600, -1, 0, 1000);
    repeat (40) @(negedge clk);
    idle(30);
    nchk++; if (fe_cnt - f0 !== 1) $display("FAIL ferr_count: got %0d want 1", fe_cnt - f0); else npass++;
    nchk++; if (dv_q.size() !== b0) $display("FAIL ferr_dv: got %0d want %0d", dv_q.size(), b0); else npass++;
    nchk++; if (rx_data !== exp_rx) $display("FAIL ferr_rx_data: got %h want %h", rx_data, exp_rx); else npass++;
    send_frame(8'h5A, 1'b1, 1600, -1, 0, 1000);
    idle(30);
    exp_rx = 8'h5A;
    nchk++; if (dv_q.size() - b0 !== 1) $display("FAIL ferr_recover_count: got %0d want 1", dv_q.size() - b0); else npass++;
    nchk++; if (rx_data !== 8'h5A) $display("FAIL ferr_recover_data: got %h want 5a", rx_data); else npass++;
  endtask

  task automatic test_spike();
    int b0;
    b0 = dv_q.size();
    send_frame(8'hC3, 1'b1, 1600, 4, H + 1, 1000);
    idle(30);
    exp_rx = 8'hC3;
    nchk++; if (dv_q.size() - b0 !== 1) $display("FAIL spike_count: got %0d want 1", dv_q.size() - b0); else npass++;
    nchk++; if (rx_data !== 8'hC3) $display("FAIL spike_data: got %h want c3", rx_data); else npass++;
  endtask

  task automatic test_reset_mid();
    int b0, f0;
    b0 = dv_q.size(); f0 = fe_cnt;
    send_frame(8'h77, 1'b1, 1600, -1, 0, 5 * CPB + H);
    @(negedge clk); rst_n = 1'b0; rxd = 1'b1;
    repeat (2) @(negedge clk);
    nchk++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else npass++;
    rst_n = 1'b1;
    idle(30);
    exp_rx = 8'h00;
    nchk++; if (rx_data !== 8'h00) $display("FAIL rstmid_rx_data: got %h want 00", rx_data); else npass++;
    nchk++; if (dv_q.size() !== b0 || fe_cnt !== f0)
      $display("FAIL rstmid_strobes: got dv %0d fe %0d want 0 0", dv_q.size() - b0, fe_cnt - f0); else npass++;
    send_frame(8'h21, 1'b1, 1600, -1, 0, 1000);
    idle(30);
    exp_rx = 8'h21;
    nchk++; if (dv_q.size() - b0 !== 1 || rx_data !== 8'h21)
      $display("FAIL rstmid_next: got %0d frames data %h want 1 frame data 21", dv_q.size() - b0, rx_data); else npass++;
  endtask

  task automatic test_baud();
    int         b0;
    int         per[2];
    logic [7:0] d[2];
    per = '{1648, 1552};
    b0 = dv_q.size();
    for (int k = 0; k < 2; k++) begin
      d[k] = 8'($urandom);
      send_frame(d[k], 1'b1, per[k], -1, 0, 1000);
      idle(20);
    end
    nchk++; if (dv_q.size() - b0 !== 2) $display("FAIL baud_count: got %0d want 2", dv_q.size() - b0); else npass++;
    for (int k = 0; k < 2 && b0 + k < dv_q.size(); k++) begin
      nchk++; if (dv_q[b0+k] !== d[k]) $display("FAIL baud_data%0d: got %h want %h", k, dv_q[b0+k], d[k]); else npass++;
    end
    exp_rx = d[1];
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] d;
    logic       good;
    int         b0, f0, exp_fe;
    b0 = dv_q.size(); f0 = fe_cnt; exp_fe = 0;
    for (int k = 0; k < 24; k++) begin
      d    = 8'($urandom);
      good = ($urandom_range(0, 4) != 0);
      send_frame(d, good, 1600, -1, 0, 1000);
      if (good) begin
        exp_q.push_back(d);
        exp_rx = d;
        if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 5));
      end else begin
        exp_fe++;
        idle($urandom_range(20, 30));
      end
    end
    idle(30);
    nchk++; if (dv_q.size() - b0 !== exp_q.size()) $display("FAIL rand_count: got %0d want %0d", dv_q.size() - b0, exp_q.size()); else npass++;
    for (int k = 0; k < exp_q.size() && b0 + k < dv_q.size(); k++) begin
      nchk++; if (dv_q[b0+k] !== exp_q[k]) $display("FAIL rand_data%0d: got %h want %h", k, dv_q[b0+k], exp_q[k]); else npass++;
    end
    nchk++; if (fe_cnt - f0 !== exp_fe) $display("FAIL rand_fe: got %0d want %0d", fe_cnt - f0, exp_fe); else npass++;
    nchk++; if (rx_data !== exp_rx) $display("FAIL rand_rx_data: got %h want %h", rx_data, exp_rx); else npass++;
  endtask

  task automatic test_strobes();
    nchk++; if (both_cnt !== 0) $display("FAIL strobe_overlap: got %0d want 0", both_cnt); else npass++;
    nchk++; if (multi_cnt !== 0) $display("FAIL strobe_width: got %0d multi-cycle strobes want 0", multi_cnt); else npass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_false_start();
    test_frame_err();
    test_spike();
    test_reset_mid();
    test_baud();
    test_random();
    test_strobes();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/uart_byte_rx.md
Name: uart_byte_rx

Overview:
- Asynchronous serial receiver, 8N1 format, LSB first. It sits directly upstream of the command parser that builds the DDS frequency word and amplitude word.
- Converts the raw rxd line into byte-wide rx_data, qualified by a single-cycle data_valid strobe.
- Filters false starts and line noise. Flags framing errors and discards the affected byte, so the parser only ever sees clean bytes.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per bit period (50 MHz / 115200). Must be >= 8.
- H (localparam), CLKS_PER_BIT/2 with integer truncation; mid-bit sample point.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- rxd  in  1  asynchronous serial line, idle high
- rx_data  out  8  last correctly framed byte
- data_valid  out  1  one-cycle strobe; rx_data is valid while high
- frame_err  out  1  one-cycle strobe; stop bit read as 0
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: rst_n is synchronous and active-low; clock is clk. While rst_n is low:
  - state = IDLE, rx_data = 0, data_valid = 0, frame_err = 0.
  - bit counter = 0, bit index = 0, shift register = 0.
  - Both synchronizer flops preset to 1.
- Synchronizer: rxd passes through 2 flops to give rxd_s. rxd_s is the only source used by the logic below.
- Bit counter: cnt runs 0..CLKS_PER_BIT-1 within each bit. cnt = 0 corresponds to the first cycle of the bit.
- Majority vote: rxd_s is sampled at cnt = H-1, H and H+1. vote = majority of the 3 samples; it is valid at cnt = H+1.
- States and transitions:
  - IDLE: when rxd_s == 0, go to START with cnt = 0.
  - START:
    - At cnt = H+1: if vote == 1, treat as a false start and return to IDLE with no strobes.
    - At cnt = CLKS_PER_BIT-1: go to DATA with cnt = 0 and bit index = 0.
  - DATA:
    - At cnt = H+1: shift register <= {vote, shift[7:1]}.
    - At cnt = CLKS_PER_BIT-1: increment bit index. After bit index 7 completes, go to STOP with cnt = 0.
  - STOP, at cnt = H+1:
    - vote == 1: rx_data <= shift register, data_valid = 1 next cycle, go to IDLE.
    - vote == 0: frame_err = 1 next cycle, rx_data unchanged, go to WAIT_IDLE.
  - Leaving STOP at mid-bit lets a back-to-back start edge be caught with no added skew.
  - WAIT_IDLE: when rxd_s == 1, go to IDLE. This handles breaks and line held low.
- Strobes: data_valid and frame_err are each high for exactly 1 clk. They are never high together. Outside their strobe cycle they are 0.
  - The downstream parser advances once per data_valid cycle, so a multi-cycle strobe is a bug.
- rx_data holds its value until the next good frame. It is never updated on a framing error or a false start.
- Latency: rxd edge to rxd_s takes 2 clk. data_valid rises (2 + 9*CLKS_PER_BIT + H + 2) clk after the start-bit falling edge on rxd.
- busy = (state != IDLE), decoded combinationally from the state register.
- Reset mid-frame: the partial byte is discarded, no strobe is issued, and the block returns to IDLE. The next falling edge starts a fresh frame.
- Back-to-back frames, stop bit followed immediately by a start bit, must be received with no loss.
- Baud tolerance: a total sender/receiver mismatch of ±3 % must still produce correct bytes.

Test Plan:
All scenarios use CLKS_PER_BIT = 16 (H = 8) and 8N1 stimulus at exactly 16 clk/bit.
1. Send 0x46 ('F') after reset with the line idle -> exactly one data_valid pulse; rx_data = 0x46; frame_err never high; busy returns to 0.
2. Send 0x4D, 0x03, 0x12, 0x34, 0x56 back-to-back with no idle gap -> five data_valid pulses, rx_data = 0x4D, 0x03, 0x12, 0x34, 0x56 in order. Consecutive pulses are 160 clk apart.
3. Drive rxd low for 4 clk, then high -> busy pulses high, returns to IDLE; no data_valid; no frame_err.
4. Send 0xA5 with stop bit = 0, then hold the line low for 40 clk, then release -> one frame_err pulse, no data_valid, rx_data unchanged. Then send 0x5A -> data_valid with rx_data = 0x5A.
5. Send 0xC3 with rxd inverted for 1 clk at the cnt = H sample of data bit 3 -> majority vote rejects the spike; rx_data = 0xC3.
6. Assert rst_n low for 2 clk during data bit 4 of 0x77 -> busy = 0, no strobes, rx_data = 0. A following 0x21 is received correctly.
